// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshake and registered flags
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_SHIFT = 2'b01;
    localparam logic [1:0] GRP_LOGIC = 2'b10;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [4:0]       s1_sel;
    logic             s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    logic [1:0]              grp;
    logic [2:0]              aop;
    logic [1:0]              sop;
    logic [SHW-1:0]          s;
    logic [WIDTH-1:0]        opb;
    logic                    cin;
    logic                    sub;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          shl_w;
    logic [WIDTH:0]          lsr_w;
    logic signed [WIDTH:0]   asr_in;
    logic [WIDTH:0]          asr_w;
    logic [SHW:0]            rot_amt;
    logic [WIDTH-1:0]        rot;
    logic [WIDTH-1:0]        r_f;
    logic                    r_c;
    logic                    r_v;
    logic                    r_err;

    assign grp = s1_sel[4:3];
    assign aop = {s1_sel[0], s1_sel[1], s1_sel[2]};
    assign sop = {s1_sel[0], s1_sel[1]};
    assign s   = s1_b[SHW-1:0];

    // Shifts carry one extra bit so the last bit shifted out falls into it (0 when s = 0).
    assign shl_w   = {1'b0, s1_a} << s;
    assign lsr_w   = {s1_a, 1'b0} >> s;
    assign asr_in  = {s1_a, 1'b0};
    assign asr_w   = asr_in >>> s;
    assign rot_amt = (SHW + 1)'(WIDTH) - {1'b0, s};
    assign rot     = (s1_a << s) | (s1_a >> rot_amt);

    always_comb begin
        opb = s1_b;
        cin = 1'b0;
        sub = 1'b0;
        case (aop)
            3'b001:  cin = 1'b1;
            3'b010:  sub = 1'b1;
            3'b011:  begin sub = 1'b1; cin = 1'b1; end
            3'b100:  opb = WIDTH'(1);
            3'b101:  begin opb = WIDTH'(1); sub = 1'b1; end
            default: ;
        endcase
        if (sub)
            sum = {1'b0, s1_a} - {1'b0, opb} - {{WIDTH{1'b0}}, cin};
        else
            sum = {1'b0, s1_a} + {1'b0, opb} + {{WIDTH{1'b0}}, cin};
    end

    always_comb begin
        r_f   = '0;
        r_c   = 1'b0;
        r_v   = 1'b0;
        r_err = 1'b0;
        case (grp)
            GRP_ARITH: begin
                if (aop == 3'b110) begin
                    r_f = s1_a;
                end else if (aop != 3'b111) begin
                    r_f = sum[WIDTH-1:0];
                    r_c = sum[WIDTH];
                    if (sub)
                        r_v = (s1_a[WIDTH-1] != opb[WIDTH-1]) && (r_f[WIDTH-1] != s1_a[WIDTH-1]);
                    else
                        r_v = (s1_a[WIDTH-1] == opb[WIDTH-1]) && (r_f[WIDTH-1] != s1_a[WIDTH-1]);
                end
            end
            GRP_LOGIC: begin
                case (sop)
                    2'b00:   r_f = s1_a & s1_b;
                    2'b01:   r_f = s1_a | s1_b;
                    2'b10:   r_f = s1_a ^ s1_b;
                    default: r_f = ~s1_a;
                endcase
            end
            GRP_SHIFT: begin
                case (sop)
                    2'b00:   begin r_f = shl_w[WIDTH-1:0]; r_c = shl_w[WIDTH]; end
                    2'b01:   begin r_f = lsr_w[WIDTH:1];   r_c = lsr_w[0];     end
                    2'b10:   begin r_f = rot;              r_c = rot[0];       end
                    default: begin r_f = asr_w[WIDTH:1];   r_c = asr_w[0];     end
                endcase
            end
            default: r_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sel   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= a;
                s1_b   <= b;
                s1_sel <= sel;
            end
        end
    end

    // Output register holds until taken; it only reloads when stage 2 is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                f      <= r_f;
                flag_z <= (r_f == '0);
                flag_n <= r_f[WIDTH-1];
                flag_c <= r_c;
                flag_v <= r_v;
                err    <= r_err;
            end
        end
    end

endmodule
